// File: rtl/uart_line_parser.sv
// Assembles UART receiver bytes into a held line buffer, terminated by CR/LF,
// and flags an exact match against the "Hello ALINX AX7102" greeting.
module uart_line_parser #(
  parameter int unsigned MAX_LEN     = 32,
  parameter int unsigned TIMEOUT_CYC = 262143,
  localparam int unsigned ADDR_W     = $clog2(MAX_LEN)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rdsig,
  input  logic [7:0]        rxdata,
  output logic              line_ready,
  output logic [5:0]        line_len,
  output logic              line_match,
  input  logic              line_ack,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data,
  output logic              overflow,
  output logic              timeout,
  output logic [7:0]        drop_cnt
);

  localparam int unsigned LEN_W     = $clog2(MAX_LEN + 1);
  localparam int unsigned TMR_W     = $clog2(TIMEOUT_CYC + 1);
  localparam int unsigned MATCH_LEN = 18;
  localparam logic [8*MATCH_LEN-1:0] MATCH_STR = "Hello ALINX AX7102";

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DISCARD = 2'd2,
    HOLD    = 2'd3
  } state_t;

  state_t             state, state_n;
  logic [LEN_W-1:0]   len, len_n;
  logic [TMR_W-1:0]   timer, timer_n;
  logic               flag, flag_n;
  logic               rdsig_q;
  logic               accept, is_term, wr_en;
  logic               ovf_n, to_n;
  logic [7:0]         drop_n;
  logic [7:0]         mem [MAX_LEN];

  // True when byte b equals the greeting character at position idx.
  function automatic logic char_ok(input logic [LEN_W-1:0] idx, input logic [7:0] b);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < int'(MATCH_LEN); i++) begin
      if (int'(32'(idx)) == i) ok = (b == MATCH_STR[8*(int'(MATCH_LEN)-1-i) +: 8]);
    end
    return ok;
  endfunction

  assign accept  = rdsig & ~rdsig_q;
  assign is_term = (rxdata == 8'd13) || (rxdata == 8'd10);

  always_comb begin
    state_n = state;
    len_n   = len;
    timer_n = timer;
    flag_n  = flag;
    wr_en   = 1'b0;
    ovf_n   = 1'b0;
    to_n    = 1'b0;
    drop_n  = drop_cnt;
    case (state)
      IDLE: begin
        timer_n = '0;
        if (accept && !is_term) begin
          wr_en   = 1'b1;
          len_n   = LEN_W'(1);
          flag_n  = char_ok('0, rxdata);
          state_n = COLLECT;
        end
      end
      COLLECT, DISCARD: begin
        if (accept) begin
          timer_n = '0;
          if (state == DISCARD) begin
            if (is_term) begin
              len_n   = '0;
              state_n = IDLE;
            end
          end else if (is_term) begin
            state_n = HOLD;
          end else if (32'(len) < MAX_LEN) begin
            wr_en  = 1'b1;
            len_n  = len + LEN_W'(1);
            flag_n = flag && char_ok(len, rxdata);
          end else begin
            ovf_n   = 1'b1;
            state_n = DISCARD;
          end
        end else if (timer == TMR_W'(TIMEOUT_CYC - 1)) begin
          // Idle too long mid-line: drop whatever was partially collected.
          to_n    = 1'b1;
          timer_n = '0;
          len_n   = '0;
          state_n = IDLE;
        end else begin
          timer_n = timer + TMR_W'(1);
        end
      end
      HOLD: begin
        timer_n = '0;
        if (accept && drop_cnt != 8'hFF) drop_n = drop_cnt + 8'd1;
        if (line_ack) begin
          len_n   = '0;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      len        <= '0;
      timer      <= '0;
      flag       <= 1'b0;
      rdsig_q    <= 1'b0;
      line_ready <= 1'b0;
      line_len   <= '0;
      line_match <= 1'b0;
      rd_data    <= '0;
      overflow   <= 1'b0;
      timeout    <= 1'b0;
      drop_cnt   <= '0;
    end else begin
      state      <= state_n;
      len        <= len_n;
      timer      <= timer_n;
      flag       <= flag_n;
      rdsig_q    <= rdsig;
      line_ready <= (state_n == HOLD);
      line_len   <= (state_n == HOLD) ? 6'(len_n) : 6'd0;
      line_match <= (state_n == HOLD) && flag_n && (32'(len_n) == MATCH_LEN);
      rd_data    <= mem[rd_addr];
      overflow   <= ovf_n;
      timeout    <= to_n;
      drop_cnt   <= drop_n;
    end
  end

  // Line storage; written only while collecting, so a held line stays intact.
  always_ff @(posedge clk) begin
    if (rst_n && wr_en) mem[len[ADDR_W-1:0]] <= rxdata;
  end

endmodule

// File: tb/tb_uart_line_parser.sv
// Randomized bench for uart_line_parser against a queue-based line model.
module tb_uart_line_parser;

  localparam int unsigned MAX_LEN = 32;
  localparam int unsigned TO      = 64;
  localparam int unsigned AW      = 5;

  logic          clk = 1'b0;
  logic          rst_n, rdsig, line_ack;
  logic [7:0]    rxdata;
  logic [AW-1:0] rd_addr;
  logic          line_ready, line_match, overflow, timeout;
  logic [5:0]    line_len;
  logic [7:0]    rd_data, drop_cnt;

  uart_line_parser #(.MAX_LEN(MAX_LEN), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst_n(rst_n), .rdsig(rdsig), .rxdata(rxdata),
    .line_ready(line_ready), .line_len(line_len), .line_match(line_match),
    .line_ack(line_ack), .rd_addr(rd_addr), .rd_data(rd_data),
    .overflow(overflow), .timeout(timeout), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: current/held line as a byte queue plus a few mode flags.
  logic [7:0] line_q[$];
  bit         held, discarding;
  int         drop, since_acc;
  string      hello = "Hello ALINX AX7102";

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit is_hello();
    if (line_q.size() != hello.len()) return 1'b0;
    for (int i = 0; i < hello.len(); i++)
      if (line_q[i] != 8'(hello[i])) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit active();
    return !held && (discarding || line_q.size() > 0);
  endfunction

  task automatic check_status();
    check("line_ready", 32'(line_ready), 32'(held));
    check("line_len", 32'(line_len), held ? line_q.size() : 0);
    check("line_match", 32'(line_match), 32'(held && is_hello()));
    check("drop_cnt", 32'(drop_cnt), drop);
  endtask

  task automatic tick();
    bit exp_to;
    @(negedge clk);
    since_acc++;
    exp_to = active() && (since_acc == int'(TO));
    if (exp_to) begin
      line_q.delete();
      discarding = 1'b0;
    end
    check("timeout", 32'(timeout), 32'(exp_to));
    check("overflow_idle", 32'(overflow), 0);
  endtask

  task automatic send_byte(input logic [7:0] b, input int hold, input bit with_ack);
    bit was_held, term, exp_ovf;
    rdsig    = 1'b1;
    rxdata   = b;
    line_ack = with_ack;
    @(negedge clk);
    was_held = held;
    term     = (b == 8'd10) || (b == 8'd13);
    exp_ovf  = 1'b0;
    if (was_held) begin
      if (drop < 255) drop++;
    end else if (discarding) begin
      if (term) discarding = 1'b0;
    end else if (line_q.size() == 0) begin
      if (!term) line_q.push_back(b);
    end else if (term) begin
      held = 1'b1;
    end else if (line_q.size() < MAX_LEN) begin
      line_q.push_back(b);
    end else begin
      exp_ovf    = 1'b1;
      discarding = 1'b1;
      line_q.delete();
    end
    if (with_ack && was_held) begin
      held = 1'b0;
      line_q.delete();
    end
    since_acc = 0;
    line_ack  = 1'b0;
    check("overflow", 32'(overflow), 32'(exp_ovf));
    check("timeout_acc", 32'(timeout), 0);
    check_status();
    for (int i = 1; i < hold; i++) tick();
    rdsig = 1'b0;
    tick();
  endtask

  task automatic send_str(input string s, input int hold);
    for (int i = 0; i < s.len(); i++) send_byte(8'(s[i]), hold, 1'b0);
  endtask

  task automatic do_ack();
    line_ack = 1'b1;
    tick();
    if (held) begin
      held = 1'b0;
      line_q.delete();
    end
    line_ack = 1'b0;
    check_status();
  endtask

  task automatic read_buf();
    for (int i = 0; i < line_q.size(); i++) begin
      rd_addr = AW'(i);
      tick();
      tick();
      check("rd_data", 32'(rd_data), 32'(line_q[i]));
    end
  endtask

  task automatic handle_hold();
    int n;
    if (!held) return;
    n = $urandom_range(0, 2);
    for (int i = 0; i < n; i++) send_byte(8'($urandom_range(32, 126)), $urandom_range(1, 3), 1'b0);
    read_buf();
    if ($urandom_range(0, 2) == 0) send_byte(8'($urandom_range(32, 126)), 1, 1'b1);
    else do_ack();
  endtask

  task automatic send_rand_line();
    int    kind, n;
    string s;
    kind = $urandom_range(0, 4);
    s = "";
    case (kind)
      0: s = hello;
      1: begin
        s = hello;
        n = $urandom_range(0, 17);
        s[n] = (s[n] == "H") ? "h" : "H";
      end
      2: begin
        n = $urandom_range(1, 40);
        for (int i = 0; i < n; i++) s = {s, string'(8'($urandom_range(32, 126)))};
      end
      3: s = hello.substr(0, $urandom_range(0, 17));
      default: begin
        n = $urandom_range(1, 5);
        for (int i = 0; i < n; i++) s = {s, string'(8'($urandom_range(65, 90)))};
        send_str(s, $urandom_range(1, 3));
        repeat (TO + 2) tick();
        return;
      end
    endcase
    send_str(s, $urandom_range(1, 3));
    case ($urandom_range(0, 2))
      0: send_byte(8'd13, 1, 1'b0);
      1: send_byte(8'd10, 1, 1'b0);
      default: begin
        send_byte(8'd13, 1, 1'b0);
        send_byte(8'd10, 1, 1'b0);
      end
    endcase
    handle_hold();
  endtask

  initial begin
    rst_n = 1'b0; rdsig = 1'b0; rxdata = '0; line_ack = 1'b0; rd_addr = '0;
    held = 1'b0; discarding = 1'b0; drop = 0; since_acc = 0;
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(line_ready), 0);
    check("rst_len", 32'(line_len), 0);
    check("rst_match", 32'(line_match), 0);
    check("rst_rd_data", 32'(rd_data), 0);
    check("rst_overflow", 32'(overflow), 0);
    check("rst_timeout", 32'(timeout), 0);
    check("rst_drop", 32'(drop_cnt), 0);
    rst_n = 1'b1;
    tick();

    // Greeting with CR, then LF arriving after release is ignored
    send_str(hello, 1);
    send_byte(8'd13, 1, 1'b0);
    check("t1_ready", 32'(line_ready), 1);
    check("t1_match", 32'(line_match), 1);
    read_buf();
    do_ack();
    send_byte(8'd10, 1, 1'b0);

    send_str("Hello ALINX AX7103", 1); send_byte(8'd10, 1, 1'b0);
    check("t2_nomatch", 32'(line_match), 0);
    handle_hold();
    send_str("Hello", 1); send_byte(8'd10, 1, 1'b0);
    handle_hold();

    // Overflow, then a short line recovers
    for (int i = 0; i < 40; i++) send_byte(8'h41, 1, 1'b0);
    send_byte(8'd10, 1, 1'b0);
    check("t3_no_line", 32'(line_ready), 0);
    send_str("ok", 1); send_byte(8'd10, 1, 1'b0);
    handle_hold();

    // Timeout mid-line
    send_str("abc", 1);
    repeat (TO + 5) tick();
    send_str("xy", 1); send_byte(8'd10, 1, 1'b0);
    read_buf();
    do_ack();

    // Drops while held, last coinciding with ack
    send_str("qq", 1); send_byte(8'd10, 1, 1'b0);
    send_byte(8'h55, 2, 1'b0);
    send_byte(8'h66, 1, 1'b0);
    read_buf();
    send_byte(8'h77, 1, 1'b1);

    // Long rdsig levels count once
    send_str("Hi", 5); send_byte(8'd10, 5, 1'b0);
    read_buf();
    do_ack();

    for (int k = 0; k < 120; k++) send_rand_line();

    // drop_cnt saturation
    send_str("z", 1); send_byte(8'd10, 1, 1'b0);
    for (int i = 0; i < 260; i++) send_byte(8'($urandom_range(32, 126)), 1, 1'b0);
    check("sat_drop", 32'(drop_cnt), 255);
    do_ack();

    // Reset mid-line
    send_str("abc", 1);
    rst_n = 1'b0;
    line_q.delete(); held = 1'b0; discarding = 1'b0; drop = 0;
    tick();
    check("mid_rst_ready", 32'(line_ready), 0);
    check("mid_rst_len", 32'(line_len), 0);
    check("mid_rst_rd", 32'(rd_data), 0);
    check("mid_rst_drop", 32'(drop_cnt), 0);
    rst_n = 1'b1;
    tick();
    send_str("ok", 1); send_byte(8'd10, 1, 1'b0);
    read_buf();
    do_ack();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
